// File: rtl/imem_refill_pkg.sv
// rtl/imem_refill_pkg.sv - shared line/beat geometry and FSM encoding for the imem line-fill path
package imem_refill_pkg;

  localparam int IMEM_LINE_W = 256;
  localparam int IMEM_BEAT_W = 64;
  localparam int IMEM_ADDR_W = 64;

  localparam int NBEATS = IMEM_LINE_W / IMEM_BEAT_W;
  localparam int OFFS   = $clog2(IMEM_LINE_W / 8);

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/imem_line_asm.sv
// rtl/imem_line_asm.sv - beat-indexed line assembly register, beat 0 in the lowest bytes
module imem_line_asm #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BEAT_W-1:0] beat,
  output logic [LINE_W-1:0] line
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (we) begin
      line[idx*BEAT_W +: BEAT_W] <= beat;
    end
  end

endmodule

// File: rtl/imem_refill.sv
// rtl/imem_refill.sv - L1 instruction cache line-fill controller; fetches a line as bus beats
module imem_refill
  import imem_refill_pkg::*;
#(
  parameter int LINE_W = IMEM_LINE_W,
  parameter int BEAT_W = IMEM_BEAT_W,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              c_rd,
  output logic [LINE_W-1:0] c_data,
  output logic              c_dv,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  input  logic [BEAT_W-1:0] m_data,
  input  logic              m_ack
);

  localparam int NB    = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(NB);

  localparam logic [ADDR_W-1:0] LINE_MASK  = ~(ADDR_W'((LINE_W / 8) - 1));
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BEAT_W / 8);
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(NB - 1);

  state_t             state;
  logic [ADDR_W-1:0]  la;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  pc_base;
  logic               same_line;
  logic               last_beat;
  logic               asm_we;

  assign pc_base   = pc & LINE_MASK;
  assign same_line = c_rd && (pc_base == la);
  assign last_beat = (cnt == LAST_IDX);
  assign asm_we    = (state == S_FETCH) && m_ack;

  imem_line_asm #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (CNT_W)
  ) u_line_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (asm_we),
    .idx   (cnt),
    .beat  (m_data),
    .line  (c_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      la     <= '0;
      cnt    <= '0;
      m_rd   <= 1'b0;
      m_addr <= '0;
      c_dv   <= 1'b0;
    end else begin
      c_dv <= 1'b0;
      case (state)
        S_IDLE: begin
          if (c_rd) begin
            la     <= pc_base;
            cnt    <= '0;
            m_addr <= pc_base;
            m_rd   <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (m_ack) begin
            cnt    <= cnt + 1'b1;
            m_addr <= m_addr + BEAT_BYTES;
            if (last_beat) begin
              m_rd <= 1'b0;
              if (same_line) begin
                c_dv  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= S_IDLE;
              end
            end else if (!same_line) begin
              // The acked beat already retired the bus read, so there is nothing left to drain.
              m_rd  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (!same_line) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (m_ack) begin
            m_rd  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_refill.sv
// tb/tb_imem_refill.sv - directed self-checking bench for imem_refill
module tb_imem_refill;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   pc;
  logic          c_rd;
  logic [255:0]  c_data;
  logic          c_dv;
  logic [63:0]   m_addr;
  logic          m_rd;
  logic [63:0]   m_data;
  logic          m_ack;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int dv_cyc = -1;

  localparam logic [255:0] L1 = {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] L2 = {64'h8888888888888888, 64'h7777777777777777,
                                 64'h6666666666666666, 64'h5555555555555555};
  localparam logic [255:0] L3 = {64'hdddddddddddddddd, 64'hcccccccccccccccc,
                                 64'hbbbbbbbbbbbbbbbb, 64'haaaaaaaaaaaaaaaa};
  localparam logic [255:0] L4 = {64'h0404040404040404, 64'h0303030303030303,
                                 64'h0202020202020202, 64'h0101010101010101};
  localparam logic [255:0] L5 = {64'hf4f4f4f4f4f4f4f4, 64'hf3f3f3f3f3f3f3f3,
                                 64'hf2f2f2f2f2f2f2f2, 64'hf1f1f1f1f1f1f1f1};

  imem_refill dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pc     (pc),
    .c_rd   (c_rd),
    .c_data (c_data),
    .c_dv   (c_dv),
    .m_addr (m_addr),
    .m_rd   (m_rd),
    .m_data (m_data),
    .m_ack  (m_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (c_dv === 1'b1) begin
      dv_cnt++;
      dv_cyc = cyc;
    end
  endtask

  // Waits idle cycles with the address held, then acks one beat.
  task automatic beat(input logic [63:0] d, input int idle, input logic [63:0] addr);
    for (int i = 0; i < idle; i++) begin
      chk("m_addr_wait", 256'(m_addr), 256'(addr));
      tick();
    end
    chk("m_addr_beat", 256'(m_addr), 256'(addr));
    chk("m_rd_beat", 256'(m_rd), 256'(1'b1));
    m_ack  = 1'b1;
    m_data = d;
    tick();
    m_ack  = 1'b0;
    m_data = '0;
  endtask

  task automatic fill(input logic [63:0] base, input logic [255:0] line, input int waits);
    logic [255:0] l;
    l = line;
    tick();
    chk("fill_m_rd", 256'(m_rd), 256'(1'b1));
    chk("fill_m_addr0", 256'(m_addr), 256'(base));
    for (int i = 0; i < 4; i++) begin
      beat(l[i*64 +: 64], waits + ((i == 0) ? 1 : 0), base + 64'(8 * i));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pc     = '0;
    c_rd   = 1'b0;
    m_data = '0;
    m_ack  = 1'b0;
    tick();
    tick();
    chk("rst_m_rd", 256'(m_rd), 256'(1'b0));
    chk("rst_c_dv", 256'(c_dv), 256'(1'b0));
    chk("rst_m_addr", 256'(m_addr), 256'(0));
    chk("rst_c_data", c_data, 256'(0));
    rst_n = 1'b1;
    tick();

    // basic zero-wait fill
    pc = 64'h1000_0040; c_rd = 1'b1; cyc = 0; dv_cnt = 0; dv_cyc = -1;
    fill(64'h1000_0040, L1, 0);
    chk("basic_c_dv", 256'(c_dv), 256'(1'b1));
    chk("basic_dv_cyc", 256'(dv_cyc), 256'(6));
    chk("basic_c_data", c_data, L1);
    chk("basic_m_rd_off", 256'(m_rd), 256'(1'b0));
    c_rd = 1'b0;
    tick();
    chk("basic_c_dv_off", 256'(c_dv), 256'(1'b0));
    chk("basic_dv_cnt", 256'(dv_cnt), 256'(1));

    // three wait cycles before each ack
    pc = 64'h1000_0040; c_rd = 1'b1; cyc = 0; dv_cnt = 0; dv_cyc = -1;
    fill(64'h1000_0040, L1, 3);
    chk("wait_c_dv", 256'(c_dv), 256'(1'b1));
    chk("wait_dv_cyc", 256'(dv_cyc), 256'(18));
    chk("wait_c_data", c_data, L1);
    c_rd = 1'b0;
    tick();
    chk("wait_c_dv_off", 256'(c_dv), 256'(1'b0));
    chk("wait_dv_cnt", 256'(dv_cnt), 256'(1));

    // redirect abort after beat 1
    pc = 64'h1000_0040; c_rd = 1'b1; cyc = 0; dv_cnt = 0;
    tick();
    beat(L2[63:0], 1, 64'h1000_0040);
    beat(L2[127:64], 0, 64'h1000_0048);
    c_rd = 1'b0;
    tick();
    chk("abort_m_rd_drain", 256'(m_rd), 256'(1'b1));
    chk("abort_m_addr", 256'(m_addr), 256'(64'h1000_0050));
    tick();
    chk("abort_m_rd_hold", 256'(m_rd), 256'(1'b1));
    m_ack = 1'b1; m_data = 64'hdead_beef_dead_beef;
    tick();
    m_ack = 1'b0;
    chk("abort_m_rd_off", 256'(m_rd), 256'(1'b0));
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tick();
    chk("abort_stray_m_rd", 256'(m_rd), 256'(1'b0));
    chk("abort_dv_cnt", 256'(dv_cnt), 256'(0));

    pc = 64'h2000_0000; c_rd = 1'b1; cyc = 0; dv_cnt = 0; dv_cyc = -1;
    fill(64'h2000_0000, L3, 0);
    chk("new_c_dv", 256'(c_dv), 256'(1'b1));
    chk("new_dv_cyc", 256'(dv_cyc), 256'(6));
    chk("new_c_data", c_data, L3);
    c_rd = 1'b0;
    tick();

    // pc moves to a new line on the final ack
    pc = 64'h1000_0040; c_rd = 1'b1; cyc = 0; dv_cnt = 0;
    tick();
    beat(L2[63:0], 1, 64'h1000_0040);
    beat(L2[127:64], 0, 64'h1000_0048);
    beat(L2[191:128], 0, 64'h1000_0050);
    pc = 64'h3000_0000;
    beat(L2[255:192], 0, 64'h1000_0058);
    chk("stale_c_dv", 256'(c_dv), 256'(1'b0));
    chk("stale_m_rd", 256'(m_rd), 256'(1'b0));
    tick();
    chk("stale_restart_m_rd", 256'(m_rd), 256'(1'b1));
    chk("stale_restart_addr", 256'(m_addr), 256'(64'h3000_0000));
    chk("stale_dv_cnt", 256'(dv_cnt), 256'(0));

    // asynchronous reset after two beats of the new refill
    beat(64'h1234_5678_9abc_def0, 1, 64'h3000_0000);
    beat(64'h0fed_cba9_8765_4321, 0, 64'h3000_0008);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_rd", 256'(m_rd), 256'(1'b0));
    chk("arst_c_dv", 256'(c_dv), 256'(1'b0));
    chk("arst_m_addr", 256'(m_addr), 256'(0));
    chk("arst_c_data", c_data, 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1; cyc = 0; dv_cnt = 0; dv_cyc = -1;
    fill(64'h3000_0000, L4, 0);
    chk("arst_c_dv_fill", 256'(c_dv), 256'(1'b1));
    chk("arst_dv_cyc", 256'(dv_cyc), 256'(6));
    chk("arst_c_data_fill", c_data, L4);

    // back-to-back miss: c_rd stays high with a new line
    pc = 64'h1000_0060;
    tick();
    chk("b2b_c_dv_off", 256'(c_dv), 256'(1'b0));
    chk("b2b_idle_m_rd", 256'(m_rd), 256'(1'b0));
    fill(64'h1000_0060, L5, 0);
    chk("b2b_c_dv", 256'(c_dv), 256'(1'b1));
    chk("b2b_c_data", c_data, L5);
    chk("b2b_dv_cnt", 256'(dv_cnt), 256'(2));
    c_rd = 1'b0;
    tick();
    chk("b2b_c_dv_end", 256'(c_dv), 256'(1'b0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
